// File: rtl/bcd_add_pkg.sv
// Shared definitions for the BCD-add datapath: FSM encoding, request indices and priority,
// digit limit, 7-segment patterns and small helpers used by the datapath and its bench.
package bcd_add_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_SUM = 2'd1;
   localparam logic [1:0] ST_ACK      = 2'd2;

   // Request index doubles as priority: the lowest index wins when several are high.
   typedef enum logic [2:0] {
      REQ_INIT    = 3'd0,
      REQ_LOAD_A  = 3'd1,
      REQ_LOAD_B  = 3'd2,
      REQ_DISP_A  = 3'd3,
      REQ_DISP_B  = 3'd4,
      REQ_DISP_LS = 3'd5,
      REQ_DISP_MS = 3'd6
   } reqIdx_t;

   localparam int NUM_REQ = 7;

   typedef struct packed {
      logic    hit;
      reqIdx_t idx;
   } reqSel_t;

   localparam logic [3:0] MAX_DIGIT = 4'd9;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   function automatic reqSel_t pickRequest(input logic [NUM_REQ-1:0] reqVec);
      reqSel_t sel;
      sel.hit = 1'b0;
      sel.idx = REQ_INIT;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (reqVec[i]) begin
            sel.hit = 1'b1;
            sel.idx = reqIdx_t'(i[2:0]);
         end
      end
      return sel;
   endfunction

   function automatic logic [3:0] satDigit(input logic [3:0] d);
      return (d > MAX_DIGIT) ? MAX_DIGIT : d;
   endfunction

   function automatic logic [6:0] segDecode(input logic [3:0] d);
      logic [6:0] pat;
      case (d)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_DASH;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/bcd_add_datapath_adder.sv
// Two-stage pipelined single-digit BCD adder: stage 1 forms the binary sum, stage 2 splits it
// into LS/MS digits. valid tracks the pipe since the last start pulse; clear forces a settled 00.
module bcd_digit_adder
   import bcd_add_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] ls,
   output logic       ms,
   output logic       valid
);

   localparam logic [LATENCY-1:0] PendStart = 1;

   logic [4:0]         raw;
   logic [LATENCY-1:0] pend;

   // Data stages run every cycle; pend only tracks when their contents reflect the operands.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         raw   <= '0;
         ls    <= '0;
         ms    <= 1'b0;
         valid <= 1'b1;
         pend  <= '0;
      end else if (clear) begin
         raw   <= '0;
         ls    <= '0;
         ms    <= 1'b0;
         valid <= 1'b1;
         pend  <= '0;
      end else begin
         raw <= {1'b0, a} + {1'b0, b};
         if (raw > 5'd9) begin
            ls <= 4'(raw - 5'd10);
            ms <= 1'b1;
         end else begin
            ls <= raw[3:0];
            ms <= 1'b0;
         end
         if (start) begin
            pend  <= PendStart;
            valid <= 1'b0;
         end else begin
            pend <= pend << 1;
            if (pend[LATENCY-1]) valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_add_datapath.sv
// BCD-add datapath slave: four-phase acks for the controller's request strobes, two operand
// registers, pipelined BCD sum and registered display digit. SEVEN_SEG_EN enables the seg decode.
module bcd_add_datapath
   import bcd_add_pkg::*;
#(
   parameter int SUM_LATENCY = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] digitIn,
   input  logic       init,
   input  logic       loadA,
   input  logic       loadB,
   input  logic       displayA,
   input  logic       displayB,
   input  logic       displayLS,
   input  logic       displayMS,
   output logic       initAck,
   output logic       loadAAck,
   output logic       loadBAck,
   output logic       displayAAck,
   output logic       displayBAck,
   output logic       displayLSAck,
   output logic       displayMSAck,
   output logic [3:0] displayDigit,
   output logic       digitErr,
   output logic       sumValid,
   output logic [6:0] seg,
   output logic [1:0] fsmState
);

   logic [1:0]         state;
   reqIdx_t            active;
   logic [NUM_REQ-1:0] ackVec;
   logic [NUM_REQ-1:0] reqVec;
   reqSel_t            sel;
   logic               idleTake;
   logic               adderStart;
   logic               adderClear;
   logic [3:0]         opA;
   logic [3:0]         opB;
   logic [3:0]         sumLs;
   logic               sumMs;
   reqIdx_t            showIdx;
   logic [3:0]         sumDigit;

   assign reqVec = {displayMS, displayLS, displayB, displayA, loadB, loadA, init};
   assign sel    = pickRequest(reqVec);

   // Handshake: a request is taken only in IDLE (its ack is low there); the matching ack is
   // raised once the action is done and dropped on the first edge that samples the request low.
   assign idleTake   = (state == ST_IDLE) && sel.hit;
   assign adderStart = idleTake && ((sel.idx == REQ_LOAD_A) || (sel.idx == REQ_LOAD_B));
   assign adderClear = idleTake && (sel.idx == REQ_INIT);

   always_comb begin
      showIdx  = (state == ST_IDLE) ? sel.idx : active;
      sumDigit = (showIdx == REQ_DISP_MS) ? {3'b000, sumMs} : sumLs;
   end

   bcd_digit_adder #(
      .LATENCY(SUM_LATENCY)
   ) uAdder (
      .clock(clock),
      .reset(reset),
      .clear(adderClear),
      .start(adderStart),
      .a(opA),
      .b(opB),
      .ls(sumLs),
      .ms(sumMs),
      .valid(sumValid)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         active       <= REQ_INIT;
         ackVec       <= '0;
         opA          <= '0;
         opB          <= '0;
         displayDigit <= '0;
         digitErr     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (sel.hit) begin
                  active <= sel.idx;
                  case (sel.idx)
                     REQ_INIT: begin
                        opA          <= '0;
                        opB          <= '0;
                        digitErr     <= 1'b0;
                        displayDigit <= '0;
                        ackVec       <= 7'b1 << sel.idx;
                        state        <= ST_ACK;
                     end
                     REQ_LOAD_A: begin
                        opA <= satDigit(digitIn);
                        if (digitIn > MAX_DIGIT) digitErr <= 1'b1;
                        ackVec <= 7'b1 << sel.idx;
                        state  <= ST_ACK;
                     end
                     REQ_LOAD_B: begin
                        opB <= satDigit(digitIn);
                        if (digitIn > MAX_DIGIT) digitErr <= 1'b1;
                        ackVec <= 7'b1 << sel.idx;
                        state  <= ST_ACK;
                     end
                     REQ_DISP_A: begin
                        displayDigit <= opA;
                        ackVec       <= 7'b1 << sel.idx;
                        state        <= ST_ACK;
                     end
                     REQ_DISP_B: begin
                        displayDigit <= opB;
                        ackVec       <= 7'b1 << sel.idx;
                        state        <= ST_ACK;
                     end
                     default: begin
                        // Sum digits are only shown once the adder pipe has settled.
                        if (sumValid) begin
                           displayDigit <= sumDigit;
                           ackVec       <= 7'b1 << sel.idx;
                           state        <= ST_ACK;
                        end else begin
                           state <= ST_WAIT_SUM;
                        end
                     end
                  endcase
               end
            end
            ST_WAIT_SUM: begin
               if (sumValid) begin
                  displayDigit <= sumDigit;
                  ackVec       <= 7'b1 << active;
                  state        <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (!reqVec[active]) begin
                  ackVec <= '0;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               ackVec <= '0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign initAck      = ackVec[REQ_INIT];
   assign loadAAck     = ackVec[REQ_LOAD_A];
   assign loadBAck     = ackVec[REQ_LOAD_B];
   assign displayAAck  = ackVec[REQ_DISP_A];
   assign displayBAck  = ackVec[REQ_DISP_B];
   assign displayLSAck = ackVec[REQ_DISP_LS];
   assign displayMSAck = ackVec[REQ_DISP_MS];
   assign fsmState     = state;

`ifdef SEVEN_SEG_EN
   always_comb seg = segDecode(displayDigit);
`else
   assign seg = SEG_OFF;
`endif

endmodule

// File: tb/tb_bcd_add_datapath.sv
// Directed bench for bcd_add_datapath: handshake driver tasks, a spec-level operand/sum model
// compared every cycle, and literal expectations for the key sums and boundaries.
module tb_bcd_add_datapath;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] digitIn = '0;
   logic       init = 1'b0, loadA = 1'b0, loadB = 1'b0;
   logic       displayA = 1'b0, displayB = 1'b0, displayLS = 1'b0, displayMS = 1'b0;
   logic       initAck, loadAAck, loadBAck, displayAAck, displayBAck, displayLSAck, displayMSAck;
   logic [3:0] displayDigit;
   logic       digitErr, sumValid;
   logic [6:0] seg;
   logic [1:0] fsmState;
   logic [6:0] ackBus;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   bit chkEn = 1'b0;

   int mA = 0, mB = 0, mErr = 0, mDisp = 0;
   int lastWrite = -100;

   logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

   bcd_add_datapath dut (
      .clock(clock), .reset(reset), .digitIn(digitIn),
      .init(init), .loadA(loadA), .loadB(loadB), .displayA(displayA), .displayB(displayB),
      .displayLS(displayLS), .displayMS(displayMS),
      .initAck(initAck), .loadAAck(loadAAck), .loadBAck(loadBAck), .displayAAck(displayAAck),
      .displayBAck(displayBAck), .displayLSAck(displayLSAck), .displayMSAck(displayMSAck),
      .displayDigit(displayDigit), .digitErr(digitErr), .sumValid(sumValid), .seg(seg),
      .fsmState(fsmState)
   );

   assign ackBus = {displayMSAck, displayLSAck, displayBAck, displayAAck, loadBAck, loadAAck, initAck};

   always #5 clock = ~clock;
   always @(posedge clock) cycle <= cycle + 1;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // The sum is settled once two edges have passed since the last operand write.
   function automatic bit validAfter(input int edgeNo);
      return (edgeNo - lastWrite) >= 2;
   endfunction

   task automatic setReq(input int idx, input logic v);
      case (idx)
         0: init = v;
         1: loadA = v;
         2: loadB = v;
         3: displayA = v;
         4: displayB = v;
         5: displayLS = v;
         default: displayMS = v;
      endcase
   endtask

   task automatic applyModel(input int idx, input int d, input int edgeNo);
      case (idx)
         0: begin mA = 0; mB = 0; mErr = 0; mDisp = 0; lastWrite = -100; end
         1: begin mA = (d > 9) ? 9 : d; if (d > 9) mErr = 1; lastWrite = edgeNo; end
         2: begin mB = (d > 9) ? 9 : d; if (d > 9) mErr = 1; lastWrite = edgeNo; end
         3: mDisp = mA;
         4: mDisp = mB;
         5: mDisp = (mA + mB) % 10;
         default: mDisp = (mA + mB) / 10;
      endcase
   endtask

   // Full four-phase handshake on one request; hold = extra cycles the request stays high after ack.
   task automatic handshake(input int idx, input int d, input int hold);
      int reqEdge, expEdge;
      bit done;
      done = 1'b0;
      @(negedge clock);
      digitIn = 4'(d);
      setReq(idx, 1'b1);
      reqEdge = cycle + 1;
      expEdge = reqEdge;
      if (idx >= 5 && !validAfter(reqEdge - 1)) expEdge = lastWrite + 3;
      for (int n = 0; n < 6 && !done; n++) begin
         @(posedge clock);
         #1;
         if (cycle == expEdge) begin
            check($sformatf("ack_rise_req%0d", idx), {7'b0, ackBus[idx]}, 8'd1);
            applyModel(idx, d, cycle);
            done = 1'b1;
         end else begin
            check($sformatf("ack_early_req%0d", idx), {7'b0, ackBus[idx]}, 8'd0);
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clock);
         #1;
         check($sformatf("ack_hold_req%0d", idx), {7'b0, ackBus[idx]}, 8'd1);
      end
      @(negedge clock);
      setReq(idx, 1'b0);
      @(posedge clock);
      #1;
      check($sformatf("ack_fall_req%0d", idx), {7'b0, ackBus[idx]}, 8'd0);
   endtask

   always @(negedge clock) begin
      if (chkEn) begin
         check("display_digit", {4'b0, displayDigit}, 8'(mDisp));
         check("digit_err", {7'b0, digitErr}, 8'(mErr));
         check("sum_valid", {7'b0, sumValid}, {7'b0, validAfter(cycle)});
         check("ack_onehot", {7'b0, ($countones(ackBus) > 1)}, 8'd0);
`ifdef SEVEN_SEG_EN
         check("seg", {1'b0, seg}, {1'b0, segTab[mDisp]});
`else
         check("seg", {1'b0, seg}, 8'h7F);
`endif
      end
   end

   initial begin
      repeat (3) @(negedge clock);
      check("rst_acks", {1'b0, ackBus}, 8'd0);
      check("rst_disp", {4'b0, displayDigit}, 8'd0);
      check("rst_valid", {7'b0, sumValid}, 8'd1);
      check("rst_err", {7'b0, digitErr}, 8'd0);
      check("rst_state", {6'b0, fsmState}, 8'd0);
      reset = 1'b0;
      chkEn = 1'b1;

      // 7 + 8 = 15, shown after the pipe settles
      handshake(1, 7, 1);
      handshake(2, 8, 1);
      repeat (3) @(negedge clock);
      handshake(5, 0, 1);
      check("lit_7p8_ls", {4'b0, displayDigit}, 8'd5);
      handshake(6, 0, 0);
      check("lit_7p8_ms", {4'b0, displayDigit}, 8'd1);

      // 9 + 9 = 18, displayLS raised right after loadBAck falls so it must wait
      handshake(1, 9, 0);
      handshake(2, 9, 0);
      handshake(5, 0, 0);
      check("lit_9p9_ls", {4'b0, displayDigit}, 8'd8);
`ifdef SEVEN_SEG_EN
      check("lit_seg8", {1'b0, seg}, 8'h00);
`else
      check("lit_seg_off", {1'b0, seg}, 8'h7F);
`endif
      handshake(6, 0, 0);
      check("lit_9p9_ms", {4'b0, displayDigit}, 8'd1);

      // 0 + 0 = 00
      handshake(1, 0, 0);
      handshake(2, 0, 0);
      handshake(6, 0, 0);
      check("lit_0p0_ms", {4'b0, displayDigit}, 8'd0);
      handshake(5, 0, 0);

      // saturation and init
      handshake(1, 12, 0);
      check("lit_sat_err", {7'b0, digitErr}, 8'd1);
      handshake(3, 0, 0);
      check("lit_sat_a", {4'b0, displayDigit}, 8'd9);
      handshake(0, 0, 1);
      check("lit_init_err", {7'b0, digitErr}, 8'd0);
      handshake(3, 0, 0);
      handshake(4, 0, 0);

      // init while the pipe is still busy
      handshake(1, 6, 0);
      handshake(0, 0, 0);
      check("lit_init_valid", {7'b0, sumValid}, 8'd1);

      // loadB and displayA together: loadB first, displayA after loadBAck clears
      handshake(1, 3, 0);
      @(negedge clock);
      digitIn = 4'd4;
      loadB = 1'b1;
      displayA = 1'b1;
      @(posedge clock); #1;
      check("sim_loadb_ack", {7'b0, loadBAck}, 8'd1);
      check("sim_dispa_wait0", {7'b0, displayAAck}, 8'd0);
      applyModel(2, 4, cycle);
      @(negedge clock);
      loadB = 1'b0;
      @(posedge clock); #1;
      check("sim_loadb_fall", {7'b0, loadBAck}, 8'd0);
      check("sim_dispa_wait1", {7'b0, displayAAck}, 8'd0);
      @(posedge clock); #1;
      check("sim_dispa_ack", {7'b0, displayAAck}, 8'd1);
      applyModel(3, 0, cycle);
      @(negedge clock);
      displayA = 1'b0;
      @(posedge clock); #1;
      check("sim_dispa_fall", {7'b0, displayAAck}, 8'd0);
      check("lit_sim_a", {4'b0, displayDigit}, 8'd3);

      // digitIn = 15 saturates, then 3 + 9 = 12
      handshake(2, 15, 0);
      handshake(4, 0, 0);
      check("lit_15_b", {4'b0, displayDigit}, 8'd9);
      handshake(5, 0, 0);
      check("lit_3p9_ls", {4'b0, displayDigit}, 8'd2);
      handshake(6, 0, 0);

      // reset in the middle of a loadA handshake
      @(negedge clock);
      digitIn = 4'd5;
      loadA = 1'b1;
      @(posedge clock); #1;
      check("mid_loada_ack", {7'b0, loadAAck}, 8'd1);
      applyModel(1, 5, cycle);
      @(negedge clock);
      chkEn = 1'b0;
      reset = 1'b1;
      #1;
      check("mid_rst_acks", {1'b0, ackBus}, 8'd0);
      check("mid_rst_state", {6'b0, fsmState}, 8'd0);
      check("mid_rst_disp", {4'b0, displayDigit}, 8'd0);
      check("mid_rst_valid", {7'b0, sumValid}, 8'd1);
      loadA = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      mA = 0; mB = 0; mErr = 0; mDisp = 0; lastWrite = -100;
      chkEn = 1'b1;
      handshake(3, 0, 0);
      check("lit_mid_a", {4'b0, displayDigit}, 8'd0);

      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_add_datapath.md
Name: bcd_add_datapath

Overview:
Datapath slave directly downstream of the BCD-add controller. It consumes the controller's one-hot request strobes (init, loadA, loadB, displayA, displayB, displayLS, displayMS) and returns the matching acknowledge for each one using a four-phase handshake. It holds two single-digit BCD operands and computes their two-digit BCD sum in a 2-stage pipeline. It drives a registered 4-bit display digit for the board's display logic.

Parameters:
SUM_LATENCY, 2, cycles from an operand register write to sum_valid; fixed by the adder pipe depth. Only the value 2 is supported.
MAX_DIGIT, 9, largest legal BCD input; larger inputs saturate to this value.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
digitIn  input  4  operand value from the switches, sampled on a load
init  input  1  request: clear datapath
loadA  input  1  request: capture digitIn into operand A
loadB  input  1  request: capture digitIn into operand B
displayA  input  1  request: show A
displayB  input  1  request: show B
displayLS  input  1  request: show sum LS digit
displayMS  input  1  request: show sum MS digit
initAck, loadAAck, loadBAck, displayAAck, displayBAck, displayLSAck, displayMSAck  output  1 each  registered acks
displayDigit  output  4  registered digit currently shown
digitErr  output  1  sticky: an out-of-range digit was loaded
sumValid  output  1  sum pipe settled
seg  output  7  active-low 7-segment pattern (see Optional Feature)

Behaviour:
- Reset (async, active-high):
  - A=B=0, sum=00, sumValid=1, displayDigit=0, digitErr=0.
  - All acks 0, state=IDLE.
  - Reset in any state aborts the current handshake with no partial register writes.
- Handshake (four-phase):
  - Requests are sampled on the rising edge of clock.
  - The ack rises on the first edge that samples its request high (after the action completes). It holds high while the request stays high.
  - The ack falls on the first edge that samples the request low.
  - A new request is not accepted until the ack is low.
  - At most one ack is high at any time.
- Simultaneous requests sampled in IDLE: priority is init > loadA > loadB > displayA > displayB > displayLS > displayMS. Lower-priority requests wait.
- FSM states: IDLE, WAIT_SUM, ACK.
  - IDLE + init: A=B=0, sum=00, sumValid=1, digitErr=0, displayDigit=0; initAck=1; go to ACK.
  - IDLE + loadA/loadB: register <= min(digitIn, 9). digitErr is set if digitIn > 9. sumValid drops next cycle. Raise the ack; go to ACK.
  - IDLE + displayA/displayB: displayDigit <= A/B; raise the ack; go to ACK.
  - IDLE + displayLS/displayMS with sumValid=1: displayDigit <= LS digit, or {3'b000, MS digit}; raise the ack; go to ACK.
  - IDLE + displayLS/displayMS with sumValid=0: go to WAIT_SUM. When sumValid=1, perform the same action and go to ACK. Worst-case ack latency after a load is 3 cycles.
  - ACK: when the active request is sampled low, clear the ack and go to IDLE.
- Arithmetic:
  - Stage 1: raw = A + B (5-bit, range 0..18).
  - Stage 2: if raw > 9, then LS = raw - 10 and MS = 1; otherwise LS = raw and MS = 0.
  - sumValid goes high 2 cycles after the last operand write. A write during the pipe restarts the count.
- Boundaries:
  - 9+9 gives MS=1, LS=8.
  - 0+0 gives 00.
  - digitIn = 15 is stored as 9 and sets digitErr.
  - Init while sumValid=0 forces sumValid=1 immediately.

Optional Feature:
- SEVEN_SEG_EN defined: seg is a combinational active-low decode of displayDigit. Digits 0-9 show the standard patterns; values 10-15 show a lone "-" (segment g).
- Not defined: seg is tied to 7'h7F (all segments off) and the decoder is not instantiated.

Decomposition:
- Package bcd_add_pkg holds:
  - the FSM state encoding (IDLE=0, WAIT_SUM=1, ACK=2);
  - a request-index enumeration and its priority order;
  - MAX_DIGIT;
  - the 7-segment pattern constants.
- Sub-module bcd_digit_adder: the 2-stage pipelined single-digit BCD adder. Inputs are a, b and a start pulse; outputs are ls, ms and valid.

Test Plan:
- Reset mid-operation: loadA held high, reset asserted for 1 cycle → all acks 0, A=0, displayDigit=0, FSM in IDLE.
- Basic add:
  - loadA with digitIn=7, then loadB with digitIn=8 → each ack rises 1 cycle after its request.
  - Then displayLS → displayDigit=5; then displayMS → displayDigit=1.
- Wait for sum: displayLS raised the cycle after loadBAck falls → displayLSAck delayed until sumValid=1, at most 3 cycles after the loadB write, displayDigit correct.
- Saturation: loadA with digitIn=12 → A=9, digitErr=1. Then init → digitErr=0, A=B=0.
- Simultaneous requests: loadB and displayA high together → loadBAck is served first. displayAAck rises only after loadB falls and loadBAck clears.
- Segment decode: SEVEN_SEG_EN defined, displayDigit=8 → seg=7'h00. Macro undefined → seg=7'h7F.
